// File: rtl/regfile_sb.sv
// regfile_sb: parametrised decode-stage register file with a pending-write scoreboard.
//
// Two combinational read ports, one write port, and one pending bit per register.
// The pending bits mark registers whose long-latency result is still outstanding, and
// they drive the hazard unit through busy1_o/busy2_o.
//
// Special indices:
//   ZERO_IDX reads as 0.
//   PC_IDX   reads as pc_addr0_i.
//   Writes and issues to either index are ignored.
//   T_IDX    stores only the flag (write_data_i == 0), zero-extended.
//
// Optional feature macro REGFILE_BYPASS_EN:
//   Defined   - write-through bypass. A read that hits the register being written this
//               cycle returns the incoming value, and its busy flag then follows only a
//               same-cycle issue to that index.
//   Undefined - reads return the stored value and busy is the registered pending bit.

module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_IDX = 0,
    parameter int unsigned PC_IDX   = 15,
    parameter int unsigned T_IDX    = 14,
    parameter int unsigned PEEK_IDX = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [ADDR_W-1:0] rt_i,
    output logic [DATA_W-1:0] read_data1_o,
    output logic [DATA_W-1:0] read_data2_o,
    output logic              busy1_o,
    output logic              busy2_o,
    input  logic              reg_wre_i,
    input  logic [ADDR_W-1:0] write_reg_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              issue_wre_i,
    input  logic [ADDR_W-1:0] issue_reg_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pc_addr0_i,
    output logic [DATA_W-1:0] reg_peek_o,
    output logic [ADDR_W:0]   pending_cnt_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_IDX);
    localparam logic [ADDR_W-1:0] PcIdx   = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] TIdx    = ADDR_W'(T_IDX);
    localparam logic [ADDR_W-1:0] PeekIdx = ADDR_W'(PEEK_IDX);

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pending_q, pending_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

    // Qualified write / issue requests (special indices filtered out)
    logic              write_ok;
    logic              issue_ok;
    logic [DATA_W-1:0] write_val;

    // True for indices that have no storage semantics (constant zero or PC read-through)
    function automatic logic is_special(input logic [ADDR_W-1:0] idx);
        return (idx == ZeroIdx) || (idx == PcIdx);
    endfunction

    // Read mux shared by both ports
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic [DATA_W-1:0] pc,
        input logic              byp_hit,
        input logic [DATA_W-1:0] byp_val
    );
        logic [DATA_W-1:0] val;
        if (idx == ZeroIdx) begin
            val = '0;
        end else if (idx == PcIdx) begin
            val = pc;
        end else if (byp_hit) begin
            val = byp_val;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Request qualification and T-register flag formatting
    always_comb begin
        write_ok  = reg_wre_i && !is_special(write_reg_i);
        issue_ok  = issue_wre_i && !is_special(issue_reg_i);
        write_val = write_data_i;
        if (write_reg_i == TIdx) begin
            write_val = {{(DATA_W-1){1'b0}}, (write_data_i == '0)};
        end
    end

    // Next-state register contents: a write lands regardless of flush or issue
    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[write_reg_i] = write_val;
        end
    end

    // Next-state scoreboard: write clears, issue sets (issue wins), flush clears everything
    always_comb begin
        pending_d = pending_q;
        if (write_ok) begin
            pending_d[write_reg_i] = 1'b0;
        end
        if (issue_ok) begin
            pending_d[issue_reg_i] = 1'b1;
        end
        if (flush_i) begin
            pending_d = '0;
        end
    end

    // Population count of the next pending vector, registered alongside it
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pending_d[i]);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_hit1, byp_hit2;
    logic iss_hit1, iss_hit2;

    // Read ports with write-through bypass; a same-cycle issue keeps the read busy
    always_comb begin
        byp_hit1     = write_ok && (rs_i == write_reg_i);
        byp_hit2     = write_ok && (rt_i == write_reg_i);
        iss_hit1     = issue_ok && (rs_i == issue_reg_i);
        iss_hit2     = issue_ok && (rt_i == issue_reg_i);
        read_data1_o = read_sel(rs_i, regs_q[rs_i], pc_addr0_i, byp_hit1, write_val);
        read_data2_o = read_sel(rt_i, regs_q[rt_i], pc_addr0_i, byp_hit2, write_val);
        busy1_o      = 1'b0;
        busy2_o      = 1'b0;
        if (!is_special(rs_i)) begin
            busy1_o = byp_hit1 ? iss_hit1 : pending_q[rs_i];
        end
        if (!is_special(rt_i)) begin
            busy2_o = byp_hit2 ? iss_hit2 : pending_q[rt_i];
        end
    end
`else
    // Read ports without bypass: stored value and registered pending bit only
    always_comb begin
        read_data1_o = read_sel(rs_i, regs_q[rs_i], pc_addr0_i, 1'b0, write_val);
        read_data2_o = read_sel(rt_i, regs_q[rt_i], pc_addr0_i, 1'b0, write_val);
        busy1_o      = 1'b0;
        busy2_o      = 1'b0;
        if (!is_special(rs_i)) begin
            busy1_o = pending_q[rs_i];
        end
        if (!is_special(rt_i)) begin
            busy2_o = pending_q[rt_i];
        end
    end
`endif

    // Debug and status outputs straight from state
    always_comb begin
        reg_peek_o    = regs_q[PeekIdx];
        pending_cnt_o = pend_cnt_q;
    end

    // The registered count must always agree with the pending vector
    a_cnt_consistent : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_cnt_q == (ADDR_W+1)'($countones(pending_q)));

    // Special indices never become pending
    a_special_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !pending_q[ZeroIdx] && !pending_q[PcIdx]);

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed checks against hand-computed literals, then
// randomized traffic checked every cycle against an array-based behavioural model.
module tb_regfile_sb;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] rs = '0, rt = '0, wr = '0, ir = '0;
    logic [DW-1:0] wd = '0, pc = 16'h1234;
    logic          wre = 1'b0, iss = 1'b0, flush = 1'b0;
    logic [DW-1:0] rd1, rd2, peek;
    logic          busy1, busy2;
    logic [AW:0]   cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Behavioural model: register contents and pending flags
    logic [DW-1:0] m_reg  [NR];
    logic          m_pend [NR];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rs_i         (rs),
        .rt_i         (rt),
        .read_data1_o (rd1),
        .read_data2_o (rd2),
        .busy1_o      (busy1),
        .busy2_o      (busy2),
        .reg_wre_i    (wre),
        .write_reg_i  (wr),
        .write_data_i (wd),
        .issue_wre_i  (iss),
        .issue_reg_i  (ir),
        .flush_i      (flush),
        .pc_addr0_i   (pc),
        .reg_peek_o   (peek),
        .pending_cnt_o(cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the architectural rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  <= '0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (wre && wr != 0 && wr != 15) begin
                m_reg[wr]  <= (wr == 14) ? {15'b0, wd == 16'h0} : wd;
                m_pend[wr] <= 1'b0;
            end
            if (iss && ir != 0 && ir != 15 && !flush) m_pend[ir] <= 1'b1;
            if (flush) for (int i = 0; i < NR; i++) m_pend[i] <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (idx == 15) return pc;
`ifdef REGFILE_BYPASS_EN
        if (wre && idx == wr) return (wr == 14) ? {15'b0, wd == 16'h0} : wd;
`endif
        return m_reg[idx];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] idx);
        if (idx == 0 || idx == 15) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wre && idx == wr) return iss && ir == idx;
`endif
        return m_pend[idx];
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd1", 32'(rd1), 32'(exp_read(rs)));
            check("rd2", 32'(rd2), 32'(exp_read(rt)));
            check("busy1", 32'(busy1), 32'(exp_busy(rs)));
            check("busy2", 32'(busy2), 32'(exp_busy(rt)));
            check("peek", 32'(peek), 32'(m_reg[3]));
            check("cnt", 32'(cnt), 32'(exp_cnt()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wre   = 1'b0;
        iss   = 1'b0;
        flush = 1'b0;
    endtask

    // Wait for the sampling edge; the caller checks, then waits #1 before driving
    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state of every index
        for (int i = 0; i < NR; i++) begin
            rs = AW'(i);
            rt = AW'(NR - 1 - i);
            at_neg();
            check("rst_rd1", 32'(rd1), (i == 15) ? 32'h1234 : 32'h0);
            check("rst_busy1", 32'(busy1), 32'h0);
            #1;
        end
        check("rst_cnt", 32'(cnt), 32'h0);
        check("rst_peek", 32'(peek), 32'h0);
        step();

        // Plain write, zero register, PC register
        wre = 1'b1; wr = 4'd5; wd = 16'hBEEF; step(); idle(); rs = 4'd5;
        at_neg(); check("wr_r5", 32'(rd1), 32'hBEEF); #1;
        wre = 1'b1; wr = 4'd0; wd = 16'hFFFF; step(); idle(); rs = 4'd0;
        at_neg(); check("wr_r0", 32'(rd1), 32'h0); #1;
        wre = 1'b1; wr = 4'd15; wd = 16'h5555; step(); idle(); rs = 4'd15;
        at_neg(); check("wr_pc", 32'(rd1), 32'h1234); #1;

        // T register stores the compare-to-zero flag
        wre = 1'b1; wr = 4'd14; wd = 16'h0000; step(); idle(); rs = 4'd14;
        at_neg(); check("t_zero", 32'(rd1), 32'h0001); #1;
        wre = 1'b1; wr = 4'd14; wd = 16'h0007; step(); idle();
        at_neg(); check("t_nonzero", 32'(rd1), 32'h0000); #1;

        // Scoreboard sequence
        iss = 1'b1; ir = 4'd2; step(); ir = 4'd7; step(); idle(); rs = 4'd2;
        at_neg(); check("sb_cnt2", 32'(cnt), 32'd2); check("sb_busy2", 32'(busy1), 32'h1); #1;
        wre = 1'b1; wr = 4'd2; wd = 16'h0022; step(); idle();
        at_neg(); check("sb_clr", 32'(busy1), 32'h0); check("sb_cnt1", 32'(cnt), 32'd1); #1;
        wre = 1'b1; wr = 4'd7; wd = 16'h0077; iss = 1'b1; ir = 4'd7; step(); idle(); rs = 4'd7;
        at_neg();
        check("waw_busy", 32'(busy1), 32'h1);
        check("waw_cnt", 32'(cnt), 32'd1);
        check("waw_data", 32'(rd1), 32'h0077);
        #1;

        // Issue and flush on the same edge
        iss = 1'b1; ir = 4'd4; flush = 1'b1; step(); idle(); rs = 4'd4; rt = 4'd7;
        at_neg();
        check("fl_cnt", 32'(cnt), 32'd0);
        check("fl_busy4", 32'(busy1), 32'h0);
        check("fl_busy7", 32'(busy2), 32'h0);
        #1;

`ifdef REGFILE_BYPASS_EN
        wre = 1'b1; wr = 4'd6; wd = 16'h00AA; rs = 4'd6;
        at_neg(); check("byp_rd1", 32'(rd1), 32'h00AA); check("byp_busy", 32'(busy1), 32'h0);
        #1;
        step(); idle();
`endif

        // Mid-cycle asynchronous reset with a write and issue to r9 presented
        wre = 1'b1; wr = 4'd9; wd = 16'h1111; step(); idle();
        iss = 1'b1; ir = 4'd9; step(); idle(); rs = 4'd9;
        at_neg(); check("r9_busy", 32'(busy1), 32'h1); check("r9_data", 32'(rd1), 32'h1111); #1;
        step();
        wre = 1'b1; wr = 4'd9; wd = 16'hABCD; iss = 1'b1; ir = 4'd9;
        #2 rst_n = 1'b0;
        idle();
        #1;
        check("arst_r9", 32'(rd1), 32'h0);
        check("arst_busy", 32'(busy1), 32'h0);
        check("arst_cnt", 32'(cnt), 32'd0);
        step(); #1 rst_n = 1'b1;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rs    = AW'($urandom);
            rt    = AW'($urandom);
            wr    = AW'($urandom);
            ir    = AW'($urandom);
            wre   = 1'($urandom_range(0, 1));
            iss   = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 31) == 0);
            wd    = ($urandom_range(0, 7) == 0) ? 16'h0 : DW'($urandom);
            pc    = DW'($urandom);
            if ($urandom_range(0, 3) == 0) ir = wr;
            if ($urandom_range(0, 3) == 0) rs = wr;
            if ($urandom_range(0, 5) == 0) rt = ir;
            step();
        end
        idle();
        at_neg();
        chk_en = 1'b0;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
